// File: rtl/if_id_queue_pkg.sv
// Shared sizing and entry layout for the IF->ID instruction queue.
// An entry packs {pred, pc_plus4, pc, instr} from MSB to LSB.
package if_id_queue_pkg;

  localparam int unsigned IFQ_DEPTH  = 4;
  localparam int unsigned IFQ_DATA_W = 32;

  function automatic int unsigned ifq_entry_w(input int unsigned data_w);
    return 3 * data_w + 1;
  endfunction

  function automatic int unsigned ifq_off_instr(input int unsigned data_w);
    return 0 * data_w;
  endfunction

  function automatic int unsigned ifq_off_pc(input int unsigned data_w);
    return 1 * data_w;
  endfunction

  function automatic int unsigned ifq_off_pc4(input int unsigned data_w);
    return 2 * data_w;
  endfunction

  function automatic int unsigned ifq_off_pred(input int unsigned data_w);
    return 3 * data_w;
  endfunction

endpackage

// File: rtl/if_id_queue_ifq_storage.sv
// DEPTH x ENTRY_W register array: one synchronous write port, one async read port.
// Contents are never cleared; the owner tracks validity.
module if_id_queue_ifq_storage
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = IFQ_DEPTH,
  parameter int unsigned ENTRY_W = ifq_entry_w(IFQ_DATA_W),
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// IF->ID instruction queue: decouples fetch from decode stalls.
// Head entry is shown combinationally; an empty queue presents an all-zero bubble.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = IFQ_DEPTH,
  parameter int unsigned DATA_W = IFQ_DATA_W,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              STALL,
  input  logic              IF_VALID,
  input  logic [DATA_W-1:0] Instr1_IF,
  input  logic [DATA_W-1:0] Instr_PC_IF,
  input  logic [DATA_W-1:0] Instr_PC_Plus4_IF,
  input  logic              Branch_prediction_IN,
  output logic              IF_READY,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] Instr1_OUT,
  output logic [DATA_W-1:0] Instr_PC_OUT,
  output logic [DATA_W-1:0] Instr_PC_Plus4,
  output logic              Branch_prediction_OUT,
  output logic [CNT_W-1:0]  OCCUPANCY
);

  localparam int unsigned ADDR_W    = $clog2(DEPTH);
  localparam int unsigned ENTRY_W   = ifq_entry_w(DATA_W);
  localparam int unsigned OFF_INSTR = ifq_off_instr(DATA_W);
  localparam int unsigned OFF_PC    = ifq_off_pc(DATA_W);
  localparam int unsigned OFF_PC4   = ifq_off_pc4(DATA_W);
  localparam int unsigned OFF_PRED  = ifq_off_pred(DATA_W);

  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop, not_full;
  logic               store_we;
  logic [ENTRY_W-1:0] wdata, rdata;

  assign OUT_VALID = (count_q != '0);
  assign not_full  = (count_q < CNT_W'(DEPTH));
  assign pop       = OUT_VALID & ~STALL;
  // Same-cycle pop frees a slot, so a full queue can still accept.
  assign IF_READY  = not_full | pop;
  assign push      = IF_VALID & IF_READY;
  assign store_we  = push & ~FLUSH;

  assign wdata = {Branch_prediction_IN, Instr_PC_Plus4_IF, Instr_PC_IF, Instr1_IF};

  if_id_queue_ifq_storage #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_storage (
    .clk_i   (CLK),
    .we_i    (store_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Pointer and occupancy next-state; flush discards both push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (FLUSH) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign Instr1_OUT            = OUT_VALID ? rdata[OFF_INSTR +: DATA_W] : '0;
  assign Instr_PC_OUT          = OUT_VALID ? rdata[OFF_PC +: DATA_W]    : '0;
  assign Instr_PC_Plus4        = OUT_VALID ? rdata[OFF_PC4 +: DATA_W]   : '0;
  assign Branch_prediction_OUT = OUT_VALID & rdata[OFF_PRED];
  assign OCCUPANCY             = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed scenarios followed by random traffic,
// checked against a queue-based reference model.
module tb_if_id_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  typedef struct {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc4;
    logic              pred;
  } ent_t;

  logic              CLK;
  logic              RESET;
  logic              FLUSH;
  logic              STALL;
  logic              IF_VALID;
  logic [DATA_W-1:0] Instr1_IF;
  logic [DATA_W-1:0] Instr_PC_IF;
  logic [DATA_W-1:0] Instr_PC_Plus4_IF;
  logic              Branch_prediction_IN;
  logic              IF_READY;
  logic              OUT_VALID;
  logic [DATA_W-1:0] Instr1_OUT;
  logic [DATA_W-1:0] Instr_PC_OUT;
  logic [DATA_W-1:0] Instr_PC_Plus4;
  logic              Branch_prediction_OUT;
  logic [CNT_W-1:0]  OCCUPANCY;

  if_id_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .FLUSH                 (FLUSH),
    .STALL                 (STALL),
    .IF_VALID              (IF_VALID),
    .Instr1_IF             (Instr1_IF),
    .Instr_PC_IF           (Instr_PC_IF),
    .Instr_PC_Plus4_IF     (Instr_PC_Plus4_IF),
    .Branch_prediction_IN  (Branch_prediction_IN),
    .IF_READY              (IF_READY),
    .OUT_VALID             (OUT_VALID),
    .Instr1_OUT            (Instr1_OUT),
    .Instr_PC_OUT          (Instr_PC_OUT),
    .Instr_PC_Plus4        (Instr_PC_Plus4),
    .Branch_prediction_OUT (Branch_prediction_OUT),
    .OCCUPANCY             (OCCUPANCY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   checks   = 0;
  int   errors   = 0;
  int   max_occ  = 0;
  bit   started  = 1'b0;
  bit   accepted = 1'b0;
  bit   holding  = 1'b0;
  int   remaining = 0;
  logic [DATA_W-1:0] pc_next;
  ent_t cur;
  ent_t mq[$];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of entries, updated by the handshake rules.
  always @(posedge CLK) begin
    bit pop_m, ready_m, push_m;
    pop_m   = (mq.size() != 0) && !STALL;
    ready_m = (mq.size() < DEPTH) || pop_m;
    push_m  = IF_VALID && ready_m;
    accepted = push_m && RESET;
    if (!RESET) begin
      mq.delete();
      started = 1'b1;
    end else if (FLUSH) begin
      mq.delete();
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (push_m) mq.push_back(cur);
    end
  end

  // Monitor: compares DUT state and head against the model at every negedge.
  always @(negedge CLK) begin
    if (started) begin
      bit exp_valid, exp_ready;
      exp_valid = (mq.size() != 0);
      exp_ready = (mq.size() < DEPTH) || (exp_valid && !STALL);
      if (mq.size() > max_occ) max_occ = mq.size();
      chk("out_valid", DATA_W'(OUT_VALID), DATA_W'(exp_valid));
      chk("if_ready", DATA_W'(IF_READY), DATA_W'(exp_ready));
      chk("occupancy", DATA_W'(OCCUPANCY), DATA_W'(mq.size()));
      if (exp_valid) begin
        chk("head_instr", Instr1_OUT, mq[0].instr);
        chk("head_pc", Instr_PC_OUT, mq[0].pc);
        chk("head_pc4", Instr_PC_Plus4, mq[0].pc4);
        chk("head_pred", DATA_W'(Branch_prediction_OUT), DATA_W'(mq[0].pred));
      end else begin
        chk("bubble_instr", Instr1_OUT, '0);
        chk("bubble_pc", Instr_PC_OUT, '0);
        chk("bubble_pc4", Instr_PC_Plus4, '0);
        chk("bubble_pred", DATA_W'(Branch_prediction_OUT), '0);
      end
    end
  end

  task automatic new_entry();
    cur.instr = $urandom;
    cur.pc    = pc_next;
    cur.pc4   = pc_next + DATA_W'(4);
    cur.pred  = 1'($urandom_range(0, 1));
  endtask

  task automatic set_pc(input logic [DATA_W-1:0] pc);
    pc_next = pc;
    holding = 1'b0;
    new_entry();
  endtask

  // One cycle: drive inputs, take the edge, then learn whether IF's push landed.
  task automatic step(input bit want, input bit stall, input bit flush, input bit rst);
    RESET    = rst;
    FLUSH    = flush;
    STALL    = stall;
    IF_VALID = holding || (want && remaining > 0);
    Instr1_IF            = cur.instr;
    Instr_PC_IF          = cur.pc;
    Instr_PC_Plus4_IF    = cur.pc4;
    Branch_prediction_IN = cur.pred;
    @(posedge CLK);
    #1;
    holding = IF_VALID && !accepted && rst && !flush;
    if (accepted) begin
      if (remaining > 0) remaining--;
      pc_next = pc_next + DATA_W'(4);
      new_entry();
    end
  endtask

  initial begin
    RESET = 1'b0; FLUSH = 1'b0; STALL = 1'b0; IF_VALID = 1'b0;
    Instr1_IF = '0; Instr_PC_IF = '0; Instr_PC_Plus4_IF = '0; Branch_prediction_IN = 1'b0;
    set_pc(32'h0);

    repeat (2) step(0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 1);

    // Streaming with no stall: occupancy stays at most 1.
    set_pc(32'h100); remaining = 4; max_occ = 0;
    repeat (6) step(1, 0, 0, 1);
    chk("stream_max_occ", DATA_W'(max_occ), DATA_W'(1));

    // Stall fills the queue; 5th entry is held until the stall drops.
    set_pc(32'h200); remaining = 5;
    repeat (6) step(1, 1, 0, 1);
    chk("held_remaining", DATA_W'(remaining), DATA_W'(1));
    repeat (7) step(1, 0, 0, 1);

    // Full queue with simultaneous push and pop for 8 cycles.
    set_pc(32'h300); remaining = 12;
    repeat (4) step(1, 1, 0, 1);
    repeat (8) step(1, 0, 0, 1);
    chk("full_pass_remaining", DATA_W'(remaining), DATA_W'(0));
    repeat (6) step(0, 0, 0, 1);

    // Flush at occupancy 3 with a concurrent push.
    set_pc(32'h380); remaining = 3;
    repeat (3) step(1, 1, 0, 1);
    remaining = 1;
    step(1, 1, 1, 1);
    set_pc(32'h400); remaining = 1;
    repeat (3) step(1, 0, 0, 1);

    // Reset with push, pop and flush all active.
    set_pc(32'h500); remaining = 3;
    repeat (2) step(1, 1, 0, 1);
    remaining = 1;
    step(1, 0, 1, 0);
    remaining = 0;
    repeat (2) step(0, 0, 0, 1);

    // Random traffic.
    set_pc(32'h1000); remaining = 1000000;
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 150) != 0));
    end
    remaining = 0;
    repeat (DEPTH + 2) step(0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
